// File: rtl/snoop_pkg.sv
// snoop_pkg
//   Shared definitions for the snooping-bus coherence slice: bus op codes,
//   snoop message codes and the arbiter state encoding. The per-cache
//   Invalid/Exclusive/Shared controllers import the same package.
//   No ports (package). Feature macro used elsewhere: FIXED_PRIO_EN.
package snoop_pkg;

  typedef enum logic [1:0] {
    OP_RM  = 2'b00,  // read miss
    OP_INV = 2'b01,  // invalidate other copies
    OP_WM  = 2'b10,  // write miss
    OP_RSV = 2'b11   // reserved, never broadcast
  } op_e;

  typedef enum logic [0:0] {
    MSG_EMPTY = 1'b0,
    MSG_WBB   = 1'b1   // Write_Back_Block
  } msg_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BCAST = 3'd1,
    ST_SNOOP = 3'd2,
    ST_WBACK = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  // Index of the lowest set bit of an up-to-8-bit vector (0 when empty).
  function automatic logic [2:0] lowest_set8(input logic [7:0] v);
    logic [2:0] idx;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && v[i]) begin
        idx   = 3'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/snoop_rr_picker.sv
// snoop_rr_picker
//   Combinational winner selection among requesting caches.
//   Default build: round-robin, search starts at i_ptr and wraps.
//   FIXED_PRIO_EN defined: lowest index always wins and i_ptr is absent.
// Ports
//   i_req  in   NUM_CACHES  request vector
//   i_ptr  in   IW          round-robin start index (default build only)
//   o_gnt  out  NUM_CACHES  one-hot winner (all zero when no request)
module snoop_rr_picker
  import snoop_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int IW         = 2
) (
  input  logic [NUM_CACHES-1:0] i_req,
`ifndef FIXED_PRIO_EN
  input  logic [IW-1:0]         i_ptr,
`endif
  output logic [NUM_CACHES-1:0] o_gnt
);

`ifdef FIXED_PRIO_EN
  // x & -x isolates the lowest set bit.
  assign o_gnt = i_req & (~i_req + NUM_CACHES'(1));
`else
  logic [NUM_CACHES-1:0] w_mask;
  logic [NUM_CACHES-1:0] w_hi;
  logic [NUM_CACHES-1:0] w_sel;

  // Requests at or above the pointer take precedence; if none, wrap to the
  // full vector. The lowest set bit of the chosen set is the winner.
  assign w_mask = ~((NUM_CACHES'(1) << i_ptr) - NUM_CACHES'(1));
  assign w_hi   = i_req & w_mask;
  assign w_sel  = (|w_hi) ? w_hi : i_req;
  assign o_gnt  = w_sel & (~w_sel + NUM_CACHES'(1));
`endif

endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Owns the shared snooping bus. Grants one cache at a time, broadcasts its
//   op/address to the other caches, waits SNOOP_LAT cycles for snoop answers,
//   holds the bus through a snooper writeback until memory accepts it, then
//   pulses done to the owner. All outputs are registered.
//   Macro FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req/op_in/addr_in   per-cache request, op (2b each), block address (AW each)
//   snoop_wb            snooper i holds the block Exclusive and must write back
//   wb_done             memory accepted the writeback (pulse)
//   grant/done          one-hot owner / one-cycle completion pulse
//   bus_valid           one-cycle broadcast strobe
//   bus_op/addr/src     broadcast op, address and owner index
//   wb_src              index of the snooper doing the writeback
//   busy                arbiter not idle
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int AW         = 8,
  parameter int SNOOP_LAT  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CACHES-1:0]         req,
  input  logic [2*NUM_CACHES-1:0]       op_in,
  input  logic [AW*NUM_CACHES-1:0]      addr_in,
  input  logic [NUM_CACHES-1:0]         snoop_wb,
  input  logic                          wb_done,
  output logic [NUM_CACHES-1:0]         grant,
  output logic [NUM_CACHES-1:0]         done,
  output logic                          bus_valid,
  output logic [1:0]                    bus_op,
  output logic [AW-1:0]                 bus_addr,
  output logic [$clog2(NUM_CACHES)-1:0] bus_src,
  output logic [$clog2(NUM_CACHES)-1:0] wb_src,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_CACHES);
  localparam int CW = $clog2(SNOOP_LAT + 1);

  arb_state_e            r_state, w_next_state;
  logic [CW-1:0]         r_cnt, w_cnt_d;
  logic [NUM_CACHES-1:0] r_grant, w_grant_d;
  logic [NUM_CACHES-1:0] r_done, w_done_d;
  logic                  r_bus_valid, w_bus_valid_d;
  op_e                   r_bus_op, w_bus_op_d;
  logic [AW-1:0]         r_bus_addr, w_bus_addr_d;
  logic [IW-1:0]         r_bus_src, w_bus_src_d;
  logic [IW-1:0]         r_wb_src, w_wb_src_d;
  logic                  r_busy, w_busy_d;

  logic [NUM_CACHES-1:0] w_win;
  logic [1:0]            w_win_op;
  logic [AW-1:0]         w_win_addr;
  logic [NUM_CACHES-1:0] w_snoop_hit;
  logic                  w_wb_needed;
  logic                  w_snoop_last;

`ifndef FIXED_PRIO_EN
  logic [IW-1:0]         r_rr_ptr, w_rr_ptr_d;
`endif

  snoop_rr_picker #(.NUM_CACHES(NUM_CACHES), .IW(IW)) u_picker (
    .i_req (req),
`ifndef FIXED_PRIO_EN
    .i_ptr (r_rr_ptr),
`endif
    .o_gnt (w_win)
  );

  // One-hot mux of the winner's op and address.
  always_comb begin
    w_win_op   = 2'b00;
    w_win_addr = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      w_win_op   = w_win_op   | (op_in[2*i +: 2]    & {2{w_win[i]}});
      w_win_addr = w_win_addr | (addr_in[AW*i +: AW] & {AW{w_win[i]}});
    end
  end

  // The owner never snoops its own request; Invalidate never needs a writeback.
  assign w_snoop_hit  = snoop_wb & ~r_grant;
  assign w_wb_needed  = (|w_snoop_hit) && ((r_bus_op == OP_RM) || (r_bus_op == OP_WM));
  assign w_snoop_last = (r_cnt == CW'(1));

  // State register, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_bus_valid <= 1'b0;
      r_bus_op    <= OP_RM;
      r_bus_addr  <= '0;
      r_bus_src   <= '0;
      r_wb_src    <= '0;
      r_busy      <= 1'b0;
`ifndef FIXED_PRIO_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_d;
      r_grant     <= w_grant_d;
      r_done      <= w_done_d;
      r_bus_valid <= w_bus_valid_d;
      r_bus_op    <= w_bus_op_d;
      r_bus_addr  <= w_bus_addr_d;
      r_bus_src   <= w_bus_src_d;
      r_wb_src    <= w_wb_src_d;
      r_busy      <= w_busy_d;
`ifndef FIXED_PRIO_EN
      r_rr_ptr    <= w_rr_ptr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|req) w_next_state = ST_BCAST;
        else      w_next_state = ST_IDLE;
      end
      ST_BCAST: begin
        // Reserved op skips the broadcast and the snoop window entirely.
        if (r_bus_op == OP_RSV) w_next_state = ST_DONE;
        else                    w_next_state = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (w_snoop_last && w_wb_needed) w_next_state = ST_WBACK;
        else if (w_snoop_last)           w_next_state = ST_DONE;
        else                             w_next_state = ST_SNOOP;
      end
      ST_WBACK: begin
        if (wb_done) w_next_state = ST_DONE;
        else         w_next_state = ST_WBACK;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    w_grant_d     = r_grant;
    w_done_d      = '0;
    w_bus_valid_d = 1'b0;
    w_bus_op_d    = r_bus_op;
    w_bus_addr_d  = r_bus_addr;
    w_bus_src_d   = r_bus_src;
    w_wb_src_d    = r_wb_src;
    w_busy_d      = (w_next_state != ST_IDLE);
    w_cnt_d       = r_cnt;
`ifndef FIXED_PRIO_EN
    w_rr_ptr_d    = r_rr_ptr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_grant_d    = w_win;
          w_bus_op_d   = op_e'(w_win_op);
          w_bus_addr_d = w_win_addr;
          w_bus_src_d  = IW'(lowest_set8(8'(w_win)));
        end else begin
          w_grant_d    = '0;
        end
      end
      ST_BCAST: begin
        w_bus_valid_d = (r_bus_op != OP_RSV);
        w_cnt_d       = CW'(SNOOP_LAT);
      end
      ST_SNOOP: begin
        w_cnt_d = r_cnt - CW'(1);
        if (w_snoop_last && w_wb_needed) w_wb_src_d = IW'(lowest_set8(8'(w_snoop_hit)));
        else                             w_wb_src_d = r_wb_src;
      end
      ST_WBACK: w_cnt_d = r_cnt;
      ST_DONE: begin
        w_done_d  = r_grant;
        w_grant_d = '0;
`ifndef FIXED_PRIO_EN
        if (r_bus_src == IW'(NUM_CACHES - 1)) w_rr_ptr_d = '0;
        else                                  w_rr_ptr_d = r_bus_src + IW'(1);
`endif
      end
      default: begin
        w_grant_d = '0;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign bus_valid = r_bus_valid;
  assign bus_op    = r_bus_op;
  assign bus_addr  = r_bus_addr;
  assign bus_src   = r_bus_src;
  assign wb_src    = r_wb_src;
  assign busy      = r_busy;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter
//   Directed scoreboard bench for snoop_bus_arbiter (NUM_CACHES=4, AW=8,
//   SNOOP_LAT=2). Expected transactions are queued by the stimulus; a monitor
//   on the falling edge tracks grant/bus_valid and checks each done pulse.
//   Latency is counted from the first cycle grant is visible to the done
//   pulse: SNOOP_LAT+2 normally, 2 for the reserved op, and for a writeback
//   the done pulse trails the cycle carrying wb_done by two cycles.
//   Honours FIXED_PRIO_EN for the round-robin expectations.
module tb_snoop_bus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [2*N-1:0] op_in;
  logic [AW*N-1:0] addr_in;
  logic [N-1:0]  snoop_wb;
  logic          wb_done;
  logic [N-1:0]  grant, done;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic [1:0]    bus_src, wb_src;
  logic          busy;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.NUM_CACHES(N), .AW(AW), .SNOOP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_in(op_in), .addr_in(addr_in),
    .snoop_wb(snoop_wb), .wb_done(wb_done), .grant(grant), .done(done),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_src(bus_src), .wb_src(wb_src), .busy(busy)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] op;
    logic [7:0] addr;
    logic [1:0] src;
    int         bv;
    int         lat;
    bit         wb;
    logic [1:0] wb_src;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] op, input logic [7:0] a,
                      input logic [1:0] s, input int bv, input int lat,
                      input bit wb, input logic [1:0] ws);
    exp_t e;
    e.gnt = g; e.op = op; e.addr = a; e.src = s;
    e.bv = bv; e.lat = lat; e.wb = wb; e.wb_src = ws;
    sb.push_back(e);
  endtask

  // Monitor: records each transaction and checks it when done pulses.
  bit         m_active = 1'b0;
  logic [3:0] m_gnt;
  logic [1:0] m_op, m_src;
  logic [7:0] m_addr;
  int         m_gcyc, m_bv_cnt, m_bvcyc;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && grant != 4'b0) begin
        m_active = 1'b1;
        m_gnt    = grant;
        m_gcyc   = cyc;
        m_op     = bus_op;
        m_addr   = bus_addr;
        m_src    = bus_src;
        m_bv_cnt = 0;
        m_bvcyc  = 0;
      end
      if (bus_valid) begin
        m_bv_cnt++;
        m_bvcyc = cyc;
      end
      if (done != 4'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          m_e = sb.pop_front();
          chk("done",      32'(done),    32'(m_e.gnt));
          chk("grant",     32'(m_gnt),   32'(m_e.gnt));
          chk("grant_clr", 32'(grant),   32'd0);
          chk("bus_op",    32'(m_op),    32'(m_e.op));
          chk("bus_addr",  32'(m_addr),  32'(m_e.addr));
          chk("bus_src",   32'(m_src),   32'(m_e.src));
          chk("bv_count",  32'(m_bv_cnt), 32'(m_e.bv));
          if (m_e.bv > 0) chk("bv_cycle", 32'(m_bvcyc - m_gcyc), 32'd1);
          chk("latency",   32'(cyc - m_gcyc), 32'(m_e.lat));
          if (m_e.wb) chk("wb_src", 32'(wb_src), 32'(m_e.wb_src));
        end
        m_active = 1'b0;
      end
    end
  end

  task automatic wait_grant(input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(posedge clk); #1;
      if (grant != 4'b0) got = 1'b1;
    end
    chk("grant_seen", {31'b0, got}, 32'd1);
  endtask

  // Wait for ndone pulses and drop the request in the cycle of the last one.
  task automatic wait_done(input int ndone, input int bound);
    int seen = 0;
    for (int i = 0; i < bound && seen < ndone; i++) begin
      @(posedge clk); #1;
      if (done != 4'b0) seen++;
    end
    req      = 4'b0;
    snoop_wb = 4'b0;
    chk("done_count", 32'(seen), 32'(ndone));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  32'(grant),    32'd0);
    chk({tag, "_done"},   32'(done),     32'd0);
    chk({tag, "_bv"},     32'(bus_valid), 32'd0);
    chk({tag, "_op"},     32'(bus_op),   32'd0);
    chk({tag, "_addr"},   32'(bus_addr), 32'd0);
    chk({tag, "_src"},    32'(bus_src),  32'd0);
    chk({tag, "_wb_src"}, 32'(wb_src),   32'd0);
    chk({tag, "_busy"},   32'(busy),     32'd0);
  endtask

  int rr_idx;

  initial begin
    rst_n = 1'b0; req = '0; op_in = '0; addr_in = '0; snoop_wb = '0; wb_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single RM from cache 0.
    op_in = 8'h00; addr_in = 32'h0000_003C; snoop_wb = 4'b0000;
    push(4'b0001, 2'b00, 8'h3C, 2'd0, 1, LAT + 2, 1'b0, 2'd0);
    req = 4'b0001;
    wait_done(1, 20);

    // Cache 1 WM, cache 2 owns the block: writeback, memory answers after 5
    // WBACK cycles. An early wb_done while broadcasting must be ignored.
    op_in = 8'b00_00_10_00; addr_in = 32'h0000_5500; snoop_wb = 4'b0100;
    push(4'b0010, 2'b10, 8'h55, 2'd1, 1, 10, 1'b1, 2'd2);
    req = 4'b0010;
    wait_grant(20);
    wb_done = 1'b1;
    @(posedge clk); #1; wb_done = 1'b0;
    repeat (7) @(posedge clk);
    #1; wb_done = 1'b1;
    @(posedge clk); #1; wb_done = 1'b0;
    wait_done(1, 10);

    // Cache 2 Invalidate with cache 3 Exclusive: no writeback.
    op_in = 8'b00_01_00_00; addr_in = 32'h0081_0000; snoop_wb = 4'b1000;
    push(4'b0100, 2'b01, 8'h81, 2'd2, 1, LAT + 2, 1'b0, 2'd0);
    req = 4'b0100;
    wait_done(1, 20);

    // Cache 3 RM with only its own snoop bit set: masked, no writeback.
    op_in = 8'b00_00_00_00; addr_in = 32'h9E00_0000; snoop_wb = 4'b1000;
    push(4'b1000, 2'b00, 8'h9E, 2'd3, 1, LAT + 2, 1'b0, 2'd0);
    req = 4'b1000;
    wait_done(1, 20);

    // All four request together; last owner was 3, so rotation starts at 0.
    op_in = 8'b00_01_10_00; addr_in = 32'hD3C2_B1A0; snoop_wb = 4'b0000;
    for (int k = 0; k < 5; k++) begin
`ifdef FIXED_PRIO_EN
      rr_idx = 0;
`else
      rr_idx = k % 4;
`endif
      push(4'(1 << rr_idx), op_in[2*rr_idx +: 2], addr_in[8*rr_idx +: 8], 2'(rr_idx),
           1, LAT + 2, 1'b0, 2'd0);
    end
    req = 4'b1111;
    wait_done(5, 80);

    // Reserved op from cache 1: no broadcast, done two cycles after grant.
    op_in = 8'b00_00_11_00; addr_in = 32'h0000_4200; snoop_wb = 4'b0000;
    push(4'b0010, 2'b11, 8'h42, 2'd1, 0, 2, 1'b0, 2'd0);
    req = 4'b0010;
    wait_done(1, 20);

    // Reset held two cycles while waiting in WBACK: transaction dropped.
    op_in = 8'b00_10_00_00; addr_in = 32'h0077_0000; snoop_wb = 4'b0001;
    req = 4'b0100;
    wait_grant(20);
    repeat (4) @(posedge clk);
    #1;
    chk("wback_busy",   32'(busy),   32'd1);
    chk("wback_wb_src", 32'(wb_src), 32'd0);
    rst_n = 1'b0; req = 4'b0000; snoop_wb = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midrst");
    rst_n = 1'b1;
    // A stray wb_done while idle must not produce anything.
    wb_done = 1'b1;
    @(posedge clk); #1; wb_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("idle_no_done", 32'(done), 32'd0);
      chk("idle_busy",    32'(busy), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
